// File: rtl/hk_gpio_pkg.sv
// Shared register map and helpers for the housekeeping GPIO interrupt controller.
package hk_gpio_pkg;

  localparam logic [19:0] ADDR_ID        = 20'h00000;
  localparam logic [19:0] ADDR_IRQ_PEND  = 20'h00004;
  localparam logic [19:0] ADDR_DEB_TICKS = 20'h00008;
  localparam logic [19:0] ADDR_LED       = 20'h00030;
  localparam logic [19:0] BANK_BASE      = 20'h00100;
  localparam logic [19:0] BANK_STRIDE    = 20'h00020;

  localparam logic [4:0] OFF_DIR     = 5'h00;
  localparam logic [4:0] OFF_DOUT    = 5'h04;
  localparam logic [4:0] OFF_DIN     = 5'h08;
  localparam logic [4:0] OFF_RISE_EN = 5'h0C;
  localparam logic [4:0] OFF_FALL_EN = 5'h10;
  localparam logic [4:0] OFF_STATUS  = 5'h14;

  localparam logic [7:0] VERSION = 8'h02;

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{sel[i]}};
    return m;
  endfunction

endpackage

// File: rtl/hk_gpio_bank.sv
// One GPIO bank: input synchroniser, debouncer, edge detect, and the per-bank registers.
module hk_gpio_bank
  import hk_gpio_pkg::*;
#(
  parameter int unsigned PIN_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIN_W-1:0] pin,
  input  logic             tick,
  input  logic             bypass,
  input  logic             wen,
  input  logic [4:0]       reg_off,
  input  logic [PIN_W-1:0] wdata,
  input  logic [PIN_W-1:0] wmask,
  output logic [PIN_W-1:0] dir,
  output logic [PIN_W-1:0] dout,
  output logic [PIN_W-1:0] din,
  output logic [PIN_W-1:0] rise_en,
  output logic [PIN_W-1:0] fall_en,
  output logic [PIN_W-1:0] status
);

  logic [SYNC_STAGES-1:0][PIN_W-1:0] sync;
  logic [PIN_W-1:0] synced, sample, filt, filt_q, same, ev, w1c;

  assign synced = sync[SYNC_STAGES-1];
  // A pin only moves when two consecutive tick samples agree.
  assign same   = ~(synced ^ sample);
  assign ev     = (filt & ~filt_q & rise_en) | (~filt & filt_q & fall_en);
  assign w1c    = (wen && reg_off == OFF_STATUS) ? (wdata & wmask) : '0;
  assign din    = filt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= '0;
      sample  <= '0;
      filt    <= '0;
      filt_q  <= '0;
      dir     <= '0;
      dout    <= '0;
      rise_en <= '0;
      fall_en <= '0;
      status  <= '0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], pin};
      filt_q <= filt;
      if (bypass) begin
        sample <= synced;
        filt   <= synced;
      end else if (tick) begin
        sample <= synced;
        filt   <= (synced & same) | (filt & ~same);
      end
      // Set has priority over a same-cycle clear.
      status <= (status & ~w1c) | ev;
      if (wen) begin
        case (reg_off)
          OFF_DIR:     dir     <= (dir & ~wmask) | (wdata & wmask);
          OFF_DOUT:    dout    <= (dout & ~wmask) | (wdata & wmask);
          OFF_RISE_EN: rise_en <= (rise_en & ~wmask) | (wdata & wmask);
          OFF_FALL_EN: fall_en <= (fall_en & ~wmask) | (wdata & wmask);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/hk_gpio_irq.sv
// Housekeeping GPIO controller: global registers, prescaler, address decode, read mux, IRQ.
module hk_gpio_irq
  import hk_gpio_pkg::*;
#(
  parameter int unsigned PIN_W       = 8,
  parameter int unsigned N_BANKS     = 2,
  parameter int unsigned LED_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_W       = 16
) (
  input  logic                     sys_clk_i,
  input  logic                     sys_rst_i,
  input  logic [N_BANKS*PIN_W-1:0] exp_dat_i,
  output logic [N_BANKS*PIN_W-1:0] exp_dat_o,
  output logic [N_BANKS*PIN_W-1:0] exp_dir_o,
  output logic [LED_W-1:0]         led_o,
  output logic                     gpio_irq_o,
  input  logic [31:0]              sys_addr_i,
  input  logic [31:0]              sys_wdata_i,
  input  logic [3:0]               sys_sel_i,
  input  logic                     sys_wen_i,
  input  logic                     sys_ren_i,
  output logic [31:0]              sys_rdata_o,
  output logic                     sys_err_o,
  output logic                     sys_ack_o
);

  logic [19:0] off, bank_rel;
  logic [2:0]  bank_idx;
  logic [4:0]  reg_off;
  logic        bank_hit, bank_ok, reg_ok, valid, strobe, deb_wr, led_wr, tick, bypass;
  logic [31:0] wmask, rd;
  logic [DEB_W-1:0] deb_ticks, pre_cnt;
  logic [LED_W-1:0] led;
  logic [N_BANKS-1:0][PIN_W-1:0] b_dir, b_dout, b_din, b_rise, b_fall, b_status;
  logic [N_BANKS-1:0] irq_pend;
  logic unused_bits;

  assign off      = sys_addr_i[19:0];
  assign bank_rel = off - BANK_BASE;
  assign bank_hit = bank_rel < (BANK_STRIDE << 3);
  assign bank_idx = bank_rel[7:5];
  assign reg_off  = bank_rel[4:0];
  assign bank_ok  = {1'b0, bank_idx} < 4'(N_BANKS);
  assign reg_ok   = reg_off inside {OFF_DIR, OFF_DOUT, OFF_DIN, OFF_RISE_EN, OFF_FALL_EN,
                                    OFF_STATUS};
  assign wmask    = byte_mask(sys_sel_i);
  assign strobe   = sys_wen_i | sys_ren_i;
  assign deb_wr   = sys_wen_i && off == ADDR_DEB_TICKS;
  assign led_wr   = sys_wen_i && off == ADDR_LED;
  assign bypass   = deb_ticks == '0;
  assign tick     = !bypass && pre_cnt == deb_ticks - DEB_W'(1);

  assign exp_dat_o   = b_dout;
  assign exp_dir_o   = b_dir;
  assign led_o       = led;
  assign unused_bits = ^{sys_addr_i[31:20], sys_wdata_i};

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    assign irq_pend[b] = |b_status[b];
    hk_gpio_bank #(
      .PIN_W       (PIN_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_bank (
      .clk     (sys_clk_i),
      .rst     (sys_rst_i),
      .pin     (exp_dat_i[b*PIN_W +: PIN_W]),
      .tick    (tick),
      .bypass  (bypass),
      .wen     (sys_wen_i && bank_hit && bank_idx == 3'(b)),
      .reg_off (reg_off),
      .wdata   (sys_wdata_i[PIN_W-1:0]),
      .wmask   (wmask[PIN_W-1:0]),
      .dir     (b_dir[b]),
      .dout    (b_dout[b]),
      .din     (b_din[b]),
      .rise_en (b_rise[b]),
      .fall_en (b_fall[b]),
      .status  (b_status[b])
    );
  end

  always_comb begin
    rd    = '0;
    valid = 1'b0;
    if (bank_hit) begin
      valid = bank_ok && reg_ok;
      for (int unsigned i = 0; i < N_BANKS; i++) begin
        if (valid && bank_idx == 3'(i)) begin
          case (reg_off)
            OFF_DIR:     rd[PIN_W-1:0] = b_dir[i];
            OFF_DOUT:    rd[PIN_W-1:0] = b_dout[i];
            OFF_DIN:     rd[PIN_W-1:0] = b_din[i];
            OFF_RISE_EN: rd[PIN_W-1:0] = b_rise[i];
            OFF_FALL_EN: rd[PIN_W-1:0] = b_fall[i];
            OFF_STATUS:  rd[PIN_W-1:0] = b_status[i];
            default: ;
          endcase
        end
      end
    end else begin
      case (off)
        ADDR_ID: begin
          valid = 1'b1;
          rd    = {8'h00, 8'(N_BANKS), 8'(PIN_W), VERSION};
        end
        ADDR_IRQ_PEND: begin
          valid            = 1'b1;
          rd[N_BANKS-1:0]  = irq_pend;
        end
        ADDR_DEB_TICKS: begin
          valid          = 1'b1;
          rd[DEB_W-1:0]  = deb_ticks;
        end
        ADDR_LED: begin
          valid          = 1'b1;
          rd[LED_W-1:0]  = led;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      deb_ticks   <= '0;
      pre_cnt     <= '0;
      led         <= '0;
      gpio_irq_o  <= 1'b0;
      sys_ack_o   <= 1'b0;
      sys_err_o   <= 1'b0;
      sys_rdata_o <= '0;
    end else begin
      if (deb_wr || bypass || tick) pre_cnt <= '0;
      else                          pre_cnt <= pre_cnt + DEB_W'(1);
      if (deb_wr) begin
        deb_ticks <= (deb_ticks & ~wmask[DEB_W-1:0]) | (sys_wdata_i[DEB_W-1:0] & wmask[DEB_W-1:0]);
      end
      if (led_wr) begin
        led <= (led & ~wmask[LED_W-1:0]) | (sys_wdata_i[LED_W-1:0] & wmask[LED_W-1:0]);
      end
      gpio_irq_o  <= |b_status;
      sys_ack_o   <= strobe;
      sys_err_o   <= strobe && !valid;
      // Read data reflects pre-write state, so wen+ren returns the old value.
      sys_rdata_o <= (sys_ren_i && valid) ? rd : '0;
    end
  end

endmodule

// File: tb/tb_hk_gpio_irq.sv
// Self-checking bench for hk_gpio_irq against a register-map level reference model.
module tb_hk_gpio_irq;

  localparam int PIN_W = 8;
  localparam int N_BANKS = 2;
  localparam int R_DIR = 0, R_DOUT = 4, R_DIN = 8, R_RISE = 12, R_FALL = 16, R_STAT = 20;

  logic        clk, rst;
  logic [15:0] exp_dat_i;
  logic [15:0] exp_dat_o, exp_dir_o;
  logic [7:0]  led_o;
  logic        gpio_irq_o;
  logic [31:0] sys_addr_i, sys_wdata_i, sys_rdata_o;
  logic [3:0]  sys_sel_i;
  logic        sys_wen_i, sys_ren_i, sys_err_o, sys_ack_o;

  int total = 0;
  int bad = 0;

  logic [31:0] m_dir[N_BANKS], m_dout[N_BANKS], m_rise[N_BANKS], m_fall[N_BANKS];
  logic [31:0] m_stat[N_BANKS], m_pins[N_BANKS];
  logic [31:0] m_deb, m_led;

  hk_gpio_irq #(
    .PIN_W(8), .N_BANKS(2), .LED_W(8), .SYNC_STAGES(2), .DEB_W(16)
  ) dut (
    .sys_clk_i(clk), .sys_rst_i(rst), .exp_dat_i(exp_dat_i), .exp_dat_o(exp_dat_o),
    .exp_dir_o(exp_dir_o), .led_o(led_o), .gpio_irq_o(gpio_irq_o), .sys_addr_i(sys_addr_i),
    .sys_wdata_i(sys_wdata_i), .sys_sel_i(sys_sel_i), .sys_wen_i(sys_wen_i),
    .sys_ren_i(sys_ren_i), .sys_rdata_o(sys_rdata_o), .sys_err_o(sys_err_o),
    .sys_ack_o(sys_ack_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ba(input int b, input int r);
    return 32'h100 + 32'(b * 32 + r);
  endfunction

  function automatic logic [15:0] vec(input logic [31:0] a0, input logic [31:0] a1);
    logic [31:0] t0, t1;
    t0 = a0;
    t1 = a1;
    return {t1[7:0], t0[7:0]};
  endfunction

  task automatic model_reset();
    for (int b = 0; b < N_BANKS; b++) begin
      m_dir[b] = 0; m_dout[b] = 0; m_rise[b] = 0; m_fall[b] = 0; m_stat[b] = 0;
      m_pins[b] = 32'hFF;
    end
    m_deb = 0;
    m_led = 0;
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] v, output logic e);
    int o, b, r;
    o = int'(addr & 32'hFFFFF);
    v = 0;
    e = 0;
    if (o == 0) v = 32'h00020802;
    else if (o == 4) begin
      for (int i = 0; i < N_BANKS; i++) if (m_stat[i] != 0) v = v | (32'h1 << i);
    end else if (o == 8) v = m_deb;
    else if (o == 48) v = m_led;
    else if (o >= 256 && o < 256 + N_BANKS * 32) begin
      b = (o - 256) / 32;
      r = (o - 256) % 32;
      case (r)
        R_DIR:  v = m_dir[b];
        R_DOUT: v = m_dout[b];
        R_DIN:  v = m_pins[b];
        R_RISE: v = m_rise[b];
        R_FALL: v = m_fall[b];
        R_STAT: v = m_stat[b];
        default: e = 1;
      endcase
    end else e = 1;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] sel);
    int o, b, r;
    logic [31:0] m;
    m = 0;
    for (int i = 0; i < 4; i++) if (sel[i]) m = m | (32'hFF << (8 * i));
    o = int'(addr & 32'hFFFFF);
    if (o == 8) m_deb = ((m_deb & ~m) | (wd & m)) & 32'hFFFF;
    else if (o == 48) m_led = ((m_led & ~m) | (wd & m)) & 32'hFF;
    else if (o >= 256 && o < 256 + N_BANKS * 32) begin
      b = (o - 256) / 32;
      r = (o - 256) % 32;
      case (r)
        R_DIR:  m_dir[b] = ((m_dir[b] & ~m) | (wd & m)) & 32'hFF;
        R_DOUT: m_dout[b] = ((m_dout[b] & ~m) | (wd & m)) & 32'hFF;
        R_RISE: m_rise[b] = ((m_rise[b] & ~m) | (wd & m)) & 32'hFF;
        R_FALL: m_fall[b] = ((m_fall[b] & ~m) | (wd & m)) & 32'hFF;
        R_STAT: m_stat[b] = m_stat[b] & ~(wd & m);
        default: ;
      endcase
    end
  endtask

  task automatic bus(input logic we, input logic re, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] sel, output logic [31:0] rd,
                     output logic er, output logic [1:0] ak, output logic irq_at);
    @(negedge clk);
    sys_wen_i = we; sys_ren_i = re; sys_addr_i = addr; sys_wdata_i = wd; sys_sel_i = sel;
    @(negedge clk);
    sys_wen_i = 0; sys_ren_i = 0;
    rd = sys_rdata_o; er = sys_err_o; ak[1] = sys_ack_o; irq_at = gpio_irq_o;
    @(negedge clk);
    ak[0] = sys_ack_o;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] sel);
    logic [31:0] rd;
    logic er, ia;
    logic [1:0] ak;
    bus(1, 0, addr, wd, sel, rd, er, ak, ia);
    model_write(addr, wd, sel);
  endtask

  task automatic rdreg(input logic [31:0] addr, output logic [31:0] rd);
    logic er, ia;
    logic [1:0] ak;
    bus(0, 1, addr, 0, 4'h0, rd, er, ak, ia);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1; exp_dat_i = 16'hFFFF;
    sys_wen_i = 0; sys_ren_i = 0; sys_addr_i = 0; sys_wdata_i = 0; sys_sel_i = 0;
    model_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({sys_ack_o, sys_err_o, sys_rdata_o, exp_dir_o, exp_dat_o, led_o, gpio_irq_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got ack=%b err=%b rdata=%h dir=%h dat=%h led=%h irq=%b want all 0",
               sys_ack_o, sys_err_o, sys_rdata_o, exp_dir_o, exp_dat_o, led_o, gpio_irq_o);
    end
    rst = 0;
    rdreg(ba(0, R_DIN), rd);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL din_early got=%h want=%h", rd, 32'h0); end
    for (int b = 0; b < N_BANKS; b++) begin
      rdreg(ba(b, R_DIN), rd);
      total++;
      if (rd !== 32'hFF) begin bad++; $display("FAIL reset_din%0d got=%h want=%h", b, rd, 32'hFF); end
    end
    total++;
    if (gpio_irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", gpio_irq_o); end
    // Reset arriving between strobe and ack must swallow the ack.
    @(negedge clk);
    sys_ren_i = 1;
    #2 rst = 1;
    @(negedge clk);
    sys_ren_i = 0;
    total++;
    if (sys_ack_o !== 1'b0) begin bad++; $display("FAIL reset_drops_ack got=%b want=0", sys_ack_o); end
    rst = 0;
    model_reset();
    repeat (5) @(negedge clk);
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    logic er, ia;
    logic [1:0] ak;
    bus(1, 0, ba(1, R_DOUT), 32'hA5, 4'b0001, rd, er, ak, ia);
    model_write(ba(1, R_DOUT), 32'hA5, 4'b0001);
    total++;
    if (ak !== 2'b10) begin bad++; $display("FAIL lane_ack0 got=%b want=10", ak); end
    bus(1, 0, ba(1, R_DOUT), 32'hFF, 4'b0010, rd, er, ak, ia);
    model_write(ba(1, R_DOUT), 32'hFF, 4'b0010);
    total++;
    if (ak !== 2'b10) begin bad++; $display("FAIL lane_ack1 got=%b want=10", ak); end
    total++;
    if (exp_dat_o[15:8] !== 8'hA5) begin
      bad++; $display("FAIL lane_dat got=%h want=a5", exp_dat_o[15:8]);
    end
    bus(0, 1, ba(1, R_DOUT), 0, 4'h0, rd, er, ak, ia);
    total++;
    if (rd !== 32'hA5 || ak !== 2'b10) begin
      bad++; $display("FAIL lane_readback got=%h ack=%b want=000000a5 ack=10", rd, ak);
    end
  endtask

  task automatic test_random_bus();
    logic [31:0] rd, ev, addr, wd, off;
    logic er, ee, ia, we, re;
    logic [1:0] ak;
    logic [3:0] sel;
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom_range(0, 1));
      re = we ? 1'($urandom_range(0, 1)) : 1'b1;
      case ($urandom_range(0, 3))
        0: off = $urandom_range(0, 127) * 4;
        1: off = $urandom_range(0, 511);
        2: off = 32'h100 + $urandom_range(0, 7) * 32 + $urandom_range(0, 7) * 4;
        default: off = ($urandom_range(0, 1) == 1) ? 32'h30 : 32'h8;
      endcase
      addr = ($urandom << 20) | off;
      wd = $urandom;
      sel = 4'($urandom_range(0, 15));
      model_read(addr, ev, ee);
      bus(we, re, addr, wd, sel, rd, er, ak, ia);
      if (we) model_write(addr, wd, sel);
      total++;
      if (ak !== 2'b10 || er !== ee) begin
        bad++; $display("FAIL rnd_ack_err addr=%h got ack=%b err=%b want ack=10 err=%b",
                        addr, ak, er, ee);
      end
      if (re) begin
        total++;
        if (rd !== ev) begin bad++; $display("FAIL rnd_read addr=%h got=%h want=%h", addr, rd, ev); end
      end
      total++;
      if (exp_dat_o !== vec(m_dout[0], m_dout[1]) || exp_dir_o !== vec(m_dir[0], m_dir[1]) ||
          led_o !== m_led[7:0]) begin
        bad++; $display("FAIL rnd_outputs got dat=%h dir=%h led=%h want dat=%h dir=%h led=%h",
                        exp_dat_o, exp_dir_o, led_o, vec(m_dout[0], m_dout[1]),
                        vec(m_dir[0], m_dir[1]), m_led[7:0]);
      end
    end
  endtask

  task automatic test_debounce();
    logic [31:0] rd;
    int n;
    for (int b = 0; b < N_BANKS; b++) begin
      wr(ba(b, R_RISE), 0, 4'hF);
      wr(ba(b, R_FALL), 0, 4'hF);
    end
    wr(32'h8, 0, 4'hF);
    exp_dat_i = 16'h0;
    m_pins[0] = 0; m_pins[1] = 0;
    repeat (6) @(negedge clk);
    wr(ba(0, R_STAT), 32'hFF, 4'hF);
    wr(ba(1, R_STAT), 32'hFF, 4'hF);
    wr(32'h8, 4, 4'hF);
    wr(ba(0, R_RISE), 1, 4'hF);
    exp_dat_i[0] = 1'b1;
    repeat (3) @(negedge clk);
    exp_dat_i[0] = 1'b0;
    repeat (15) @(negedge clk);
    rdreg(ba(0, R_DIN), rd);
    total++;
    if (rd !== 32'h0 || gpio_irq_o !== 1'b0) begin
      bad++; $display("FAIL deb_glitch got din=%h irq=%b want din=0 irq=0", rd, gpio_irq_o);
    end
    exp_dat_i[0] = 1'b1;
    n = 0;
    while (gpio_irq_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n < 9 || n > 13) begin bad++; $display("FAIL deb_latency got=%0d want 9..13", n); end
    repeat (8) @(negedge clk);
    m_pins[0] = 1;
    m_stat[0] = 1;
    rdreg(ba(0, R_DIN), rd);
    total++;
    if (rd !== 32'h1) begin bad++; $display("FAIL deb_din got=%h want=%h", rd, 32'h1); end
    rdreg(ba(0, R_STAT), rd);
    total++;
    if (rd !== 32'h1) begin bad++; $display("FAIL deb_status got=%h want=%h", rd, 32'h1); end
    rdreg(32'h4, rd);
    total++;
    if (rd !== 32'h1 || gpio_irq_o !== 1'b1) begin
      bad++; $display("FAIL deb_pend got=%h irq=%b want=1 irq=1", rd, gpio_irq_o);
    end
  endtask

  task automatic test_fall_w1c();
    logic [31:0] rd;
    logic er, ia;
    logic [1:0] ak;
    wr(32'h8, 0, 4'hF);
    wr(ba(0, R_FALL), 2, 4'hF);
    wr(ba(0, R_STAT), 1, 4'hF);
    exp_dat_i[1] = 1'b1;
    repeat (6) @(negedge clk);
    exp_dat_i[1] = 1'b0;
    repeat (6) @(negedge clk);
    m_stat[0] = 2;
    rdreg(ba(0, R_STAT), rd);
    total++;
    if (rd !== 32'h2 || gpio_irq_o !== 1'b1) begin
      bad++; $display("FAIL fall_status got=%h irq=%b want=2 irq=1", rd, gpio_irq_o);
    end
    exp_dat_i[1] = 1'b1;
    repeat (6) @(negedge clk);
    // Fall reaches STATUS on the 4th edge after the pin moves; the W1C is aimed at that edge.
    exp_dat_i[1] = 1'b0;
    repeat (2) @(negedge clk);
    bus(1, 0, ba(0, R_STAT), 32'h2, 4'hF, rd, er, ak, ia);
    repeat (3) @(negedge clk);
    rdreg(ba(0, R_STAT), rd);
    total++;
    if (rd !== 32'h2) begin bad++; $display("FAIL set_wins got=%h want=%h", rd, 32'h2); end
    bus(1, 0, ba(0, R_STAT), 32'h2, 4'hF, rd, er, ak, ia);
    m_stat[0] = 0;
    total++;
    if (ia !== 1'b1 || gpio_irq_o !== 1'b0) begin
      bad++; $display("FAIL clear_irq got ack_cycle=%b next=%b want 1 then 0", ia, gpio_irq_o);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic er, ia;
    logic [1:0] ak;
    bus(0, 1, 32'h140, 0, 4'h0, rd, er, ak, ia);
    total++;
    if (ak !== 2'b10 || er !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL err_bank got ack=%b err=%b rd=%h want 10 1 0", ak, er, rd);
    end
    bus(0, 1, 32'h0FC, 0, 4'h0, rd, er, ak, ia);
    total++;
    if (ak !== 2'b10 || er !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL err_unmapped got ack=%b err=%b rd=%h want 10 1 0", ak, er, rd);
    end
    bus(1, 0, 32'h144, 32'hFFFF_FFFF, 4'hF, rd, er, ak, ia);
    bus(1, 0, 32'h0FC, 32'hFFFF_FFFF, 4'hF, rd, er, ak, ia);
    total++;
    if (er !== 1'b1 || exp_dat_o !== vec(m_dout[0], m_dout[1]) || exp_dir_o !== vec(m_dir[0], m_dir[1]))
    begin
      bad++; $display("FAIL err_write got err=%b dat=%h dir=%h want err=1 dat=%h dir=%h", er,
                      exp_dat_o, exp_dir_o, vec(m_dout[0], m_dout[1]), vec(m_dir[0], m_dir[1]));
    end
    bus(1, 0, ba(0, R_DIN), 32'hFF, 4'hF, rd, er, ak, ia);
    total++;
    if (er !== 1'b0 || ak !== 2'b10) begin
      bad++; $display("FAIL ro_write got err=%b ack=%b want err=0 ack=10", er, ak);
    end
    rdreg(ba(0, R_DIN), rd);
    total++;
    if (rd !== m_pins[0]) begin bad++; $display("FAIL ro_din got=%h want=%h", rd, m_pins[0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic er, ia;
    logic [1:0] ak;
    wr(32'h30, 32'h03, 4'hF);
    bus(1, 1, 32'h30, 32'h3C, 4'hF, rd, er, ak, ia);
    total++;
    if (rd !== 32'h03 || led_o !== 8'h3C || er !== 1'b0) begin
      bad++; $display("FAIL wen_ren got rd=%h led=%h err=%b want rd=03 led=3c err=0", rd, led_o, er);
    end
    rdreg(32'h0, rd);
    total++;
    if (rd !== 32'h00020802) begin bad++; $display("FAIL id got=%h want=%h", rd, 32'h00020802); end
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_random_bus();
    test_debounce();
    test_fall_w1c();
    test_errors();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hk_gpio_irq.md
# hk_gpio_irq

Parametrised housekeeping GPIO controller on the system bus. It replaces the fixed 8-bit P/N expansion-pin registers with N_BANKS banks of PIN_W pins each. Each bank adds input synchronisation, prescaled debounce, per-pin rise/fall edge detection and write-1-to-clear interrupt status. The block drives a level interrupt request to the PS and keeps the LED register and ID word at the same global offsets as before.

## Interface
Parameters:
- PIN_W, 8, pins per bank (1..32)
- N_BANKS, 2, number of banks (1..8)
- LED_W, 8, LED register width (1..32)
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- DEB_W, 16, width of debounce prescaler register

Ports (one clock; reset is asynchronous and active-high):
- sys_clk_i  in  1  bus and logic clock
- sys_rst_i  in  1  asynchronous active-high reset
- exp_dat_i  in  N_BANKS*PIN_W  pin inputs, asynchronous; bank b = bits [b*PIN_W +: PIN_W]
- exp_dat_o  out  N_BANKS*PIN_W  pin output data
- exp_dir_o  out  N_BANKS*PIN_W  1 = output enable
- led_o  out  LED_W  LED drive
- gpio_irq_o  out  1  level interrupt, registered
- sys_addr_i  in  32  bus address; bits [19:0] decoded
- sys_wdata_i  in  32  write data
- sys_sel_i  in  4  byte-lane write enables
- sys_wen_i  in  1  write strobe, one cycle
- sys_ren_i  in  1  read strobe, one cycle
- sys_rdata_o  out  32  read data, valid with ack
- sys_err_o  out  1  error, valid with ack
- sys_ack_o  out  1  acknowledge pulse

## Operation
Global register map (offsets from [19:0]):
- 0x000 ID, RO: {8'h0, N_BANKS[7:0], PIN_W[7:0], VERSION=8'h02}.
- 0x004 IRQ_PEND, RO: bit b = OR of bank b status.
- 0x008 DEB_TICKS, RW [DEB_W-1:0]. Value 0 bypasses debounce.
- 0x030 LED, RW [LED_W-1:0].

Per-bank registers, base 0x100 + b*0x20:
- +0x00 DIR, RW.
- +0x04 DOUT, RW.
- +0x08 DIN, RO: debounced value.
- +0x0C RISE_EN, RW.
- +0x10 FALL_EN, RW.
- +0x14 STATUS: RW1C.

Register rules:
- Writes honour sys_sel_i per byte lane. Bits above the field width read 0 and ignore writes.
- An unmapped offset or a bank index >= N_BANKS completes with ack=1, rdata=0, err=1. Writes to it have no effect.
- Writes to RO registers complete with ack=1 and err=0, and are ignored.

Input path, per pin: SYNC_STAGES flops, then the debouncer, then the filtered value `filt`.
- A shared prescaler counts 0..DEB_TICKS-1 and emits `tick` on wrap.
- On `tick`, each pin samples its synced input. `filt` takes the sample only when the sample equals the previous tick's sample.
- With DEB_TICKS=0, `filt` follows the synced input every cycle.
- Writing DEB_TICKS restarts the prescaler at 0.

Edge and interrupt logic:
- rise = filt & ~filt_q; fall = ~filt & filt_q.
- New events: ev = (rise & RISE_EN) | (fall & FALL_EN).
- Status update: STATUS <= (STATUS & ~w1c_mask) | ev.
- If an event and a clear hit the same bit in the same cycle, the set wins.
- gpio_irq_o is the registered OR of all bank STATUS bits.

Bus handshake:
- A wen or ren strobe gives sys_ack_o high for exactly one cycle, on the next cycle. rdata and err are registered and valid in that cycle.
- If wen and ren are high together, the write is performed and the read returns the pre-write value.
- The bus does not issue a new strobe while an ack is pending; the block does not queue strobes.

Reset values:
- All RW registers, STATUS, filt, filt_q, the synchronisers and the prescaler reset to 0.
- Outputs reset to 0: exp_dir_o, exp_dat_o, led_o, gpio_irq_o, sys_ack_o, sys_err_o, sys_rdata_o.
- All pins are inputs at reset. Because RISE_EN resets to 0, a pin already high at reset raises no event.
- Reset mid-transaction drops the pending ack.

## Timing
- Write takes effect at the ack edge (cycle N+1 for a strobe at N). exp_dat_o, exp_dir_o and led_o update in that same cycle.
- Read latency is 1 cycle.
- Pin to DIN with debounce bypassed: SYNC_STAGES+1 cycles.
- Pin to DIN with debounce: between DEB_TICKS*1 and DEB_TICKS*2 cycles plus SYNC_STAGES+1.
- filt edge to STATUS bit: 1 cycle. STATUS to gpio_irq_o: 1 cycle.
- W1C clearing the last set bit drops gpio_irq_o 1 cycle after ack.

## Structure
- Package hk_gpio_pkg holds:
  - the register offset localparams (ID, IRQ_PEND, DEB_TICKS, LED, BANK_BASE, BANK_STRIDE, and the bank register offsets);
  - VERSION;
  - the byte-lane mask helper function.
- Sub-module hk_gpio_bank, instantiated N_BANKS times via generate, contains:
  - the synchroniser, debouncer and edge detector;
  - the RISE_EN, FALL_EN and STATUS registers;
  - DIR and DOUT.
- The top level holds the prescaler, the global registers, address decode, the read mux and the IRQ OR.

## Test plan
- Reset with exp_dat_i all ones -> every output 0, DIN reads 0xFF after SYNC_STAGES+1 cycles, gpio_irq_o stays 0.
- Write 0xA5 to bank1 DOUT with sel=4'b0001, then 0xFF with sel=4'b0010 -> exp_dat_o[15:8]=0xA5, readback 0x000000A5, ack exactly one cycle each.
- Set DEB_TICKS=4 and RISE_EN=0x01 on bank0, pulse pin0 high for 3 cycles -> DIN unchanged, no IRQ. Hold high for 20 cycles -> DIN bit0=1, STATUS=0x01, IRQ_PEND=0x1, gpio_irq_o=1.
- Pin1 falling edge with FALL_EN=0x02, then write STATUS=0x02 in the same cycle as a new fall event -> bit stays set; a later clear drops gpio_irq_o 1 cycle after ack.
- Read 0x100+N_BANKS*0x20 and 0x0FC -> ack=1, err=1, rdata=0; writes there change no register.
- Simultaneous wen+ren to LED (old 0x03, write 0x3C) -> rdata=0x03, led_o=0x3C; ID read returns {8'h0,8'h02,8'h08,8'h02}.
